// File: rtl/pulse_pkg.sv
// Shared types and default sizing for the pulse hold scheduler.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_GAP_CYC = 1;

endpackage

// File: rtl/pulse_hold_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer, searching upward with wrap, receives a one-hot grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_hold_sched.sv
// Shared stretched-pulse scheduler: channels request a hold length, one is
// granted round-robin, and pulse_out stays high for that many cycles.
//
//   state | meaning
//   IDLE  | arbitrating; req_rdy may be asserted
//   HOLD  | pulse_out high, counter runs down to 0
//   GAP   | enforced low time between holds
module pulse_hold_sched
    import pulse_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_vld,
    input  logic [NUM_CH*CNT_W-1:0]    req_hold,
    output logic [NUM_CH-1:0]          req_rdy,
    input  logic                       abort,
    output logic                       pulse_out,
    output logic [$clog2(NUM_CH)-1:0]  pulse_ch,
    output logic                       busy,
    output logic                       done
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   ch_q, ch_d;

    logic [NUM_CH-1:0]  grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [CNT_W-1:0]   hold_sel;

    rr_arbiter #(
        .N     (NUM_CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_vld),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    assign hold_sel = req_hold[int'(grant_idx)*CNT_W +: CNT_W];
    assign req_rdy  = (state_q == IDLE) ? grant : '0;

    // pulse_out decodes straight from the state flop so reset clears it asynchronously
    assign pulse_out = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign pulse_ch  = ch_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_rdy) begin
                    state_d = HOLD;
                    ch_d    = grant_idx;
                    cnt_d   = (hold_sel == '0) ? '0 : hold_sel - CNT_W'(1);
                    ptr_d   = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
                end
            end
            HOLD: begin
                if (abort || cnt_q == '0) begin
                    done    = !abort;
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
        end
    end

endmodule

// File: tb/tb_pulse_hold_sched.sv
// Directed bench for pulse_hold_sched with default parameters (4 ch, 32-bit, gap 1).
module tb_pulse_hold_sched;

    logic         clk;
    logic         rst;
    logic [3:0]   req_vld;
    logic [127:0] req_hold;
    logic [3:0]   req_rdy;
    logic         abort;
    logic         pulse_out;
    logic [1:0]   pulse_ch;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    pulse_hold_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_hold  (req_hold),
        .req_rdy   (req_rdy),
        .abort     (abort),
        .pulse_out (pulse_out),
        .pulse_ch  (pulse_ch),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_hold(input int ch, input logic [31:0] val);
        req_hold[ch*32 +: 32] = val;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        req_vld  = '0;
        req_hold = '0;
        abort    = 1'b0;
        #1;
        chk("rst_pulse", 32'(pulse_out), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_ch",    32'(pulse_ch), 0);
        chk("rst_rdy",   32'(req_rdy), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single request, ch2 hold 5
        set_hold(2, 5);
        req_vld = 4'b0100;
        #1;
        chk("single_rdy", 32'(req_rdy), 32'b0100);
        tick();
        req_vld = '0;
        for (int k = 1; k <= 5; k++) begin
            chk("single_pulse", 32'(pulse_out), 1);
            chk("single_done",  32'(done), (k == 5) ? 1 : 0);
            chk("single_ch",    32'(pulse_ch), 2);
            tick();
        end
        chk("single_gap_pulse", 32'(pulse_out), 0);
        chk("single_gap_busy",  32'(busy), 1);
        chk("single_gap_done",  32'(done), 0);
        tick();
        chk("single_idle_busy", 32'(busy), 0);
        chk("single_idle_ch",   32'(pulse_ch), 2);

        // reset pointer, then all four channels continuously with hold 3
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) set_hold(c, 3);
        req_vld = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_rdy", 32'(req_rdy), 32'(1 << (g % 4)));
            tick();
            for (int k = 1; k <= 3; k++) begin
                chk("rr_pulse", 32'(pulse_out), 1);
                chk("rr_ch",    32'(pulse_ch), 32'(g % 4));
                chk("rr_done",  32'(done), (k == 3) ? 1 : 0);
                tick();
            end
            chk("rr_gap_pulse", 32'(pulse_out), 0);
            chk("rr_gap_busy",  32'(busy), 1);
            if (g == 4) req_vld = '0;
            tick();
        end

        // zero hold on ch1 (pointer now at 1)
        set_hold(1, 0);
        req_vld = 4'b0010;
        #1;
        chk("zero_rdy", 32'(req_rdy), 32'b0010);
        tick();
        req_vld = '0;
        chk("zero_pulse", 32'(pulse_out), 1);
        chk("zero_done",  32'(done), 1);
        tick();
        chk("zero_low",  32'(pulse_out), 0);
        chk("zero_busy", 32'(busy), 1);
        tick();
        chk("zero_idle", 32'(busy), 0);

        // abort on the 4th high cycle of a 100-cycle hold, ch2
        set_hold(2, 100);
        req_vld = 4'b0100;
        #1;
        chk("abort_rdy", 32'(req_rdy), 32'b0100);
        tick();
        req_vld = '0;
        for (int k = 1; k <= 3; k++) begin
            chk("abort_pulse", 32'(pulse_out), 1);
            tick();
        end
        abort = 1'b1;
        #1;
        chk("abort_cyc_pulse", 32'(pulse_out), 1);
        chk("abort_cyc_done",  32'(done), 0);
        tick();
        chk("abort_gap_pulse", 32'(pulse_out), 0);
        chk("abort_gap_busy",  32'(busy), 1);
        chk("abort_gap_done",  32'(done), 0);
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'(busy), 0);

        // async reset mid-hold on ch1 (pointer would otherwise move to 2)
        set_hold(1, 10);
        req_vld = 4'b0010;
        #1;
        chk("arst_rdy", 32'(req_rdy), 32'b0010);
        tick();
        req_vld = '0;
        chk("arst_pre_pulse", 32'(pulse_out), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_pulse", 32'(pulse_out), 0);
        chk("arst_busy",  32'(busy), 0);
        chk("arst_done",  32'(done), 0);
        chk("arst_ch",    32'(pulse_ch), 0);
        #1 rst = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) set_hold(c, 2);
        req_vld = 4'b1111;
        #1;
        chk("arst_next_rdy", 32'(req_rdy), 32'b0001);
        tick();
        req_vld = '0;
        chk("arst_next_ch", 32'(pulse_ch), 0);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("arst_drain_timeout", 32'(busy), 0);

        // withdrawn request on ch1 while ch2 holds; hold change after accept ignored
        set_hold(2, 4);
        req_vld = 4'b0100;
        #1;
        chk("wd_rdy", 32'(req_rdy), 32'b0100);
        tick();
        req_vld = 4'b0010;
        set_hold(2, 50);
        for (int k = 1; k <= 4; k++) begin
            chk("wd_pulse",   32'(pulse_out), 1);
            chk("wd_busyrdy", 32'(req_rdy), 0);
            chk("wd_done",    32'(done), (k == 4) ? 1 : 0);
            tick();
        end
        chk("wd_gap_pulse", 32'(pulse_out), 0);
        chk("wd_gap_rdy",   32'(req_rdy), 0);
        req_vld = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("wd_idle_busy", 32'(busy), 0);
            chk("wd_idle_rdy",  32'(req_rdy), 0);
            chk("wd_idle_ch",   32'(pulse_ch), 2);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_hold_sched.md
PULSE_HOLD_SCHED -- requirements
Module: pulse_hold_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of the per-request hold count.
REQ-003 SHALL have parameter GAP_CYC, default 1, number of idle cycles enforced between consecutive holds (0 allowed).
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_vld  input  NUM_CH  per-channel hold request.
REQ-007 SHALL have port req_hold  input  NUM_CH*CNT_W  per-channel hold length in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port req_rdy  output  NUM_CH  one-hot request accept, combinational.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the active hold.
REQ-010 SHALL have port pulse_out  output  1  shared stretched pulse.
REQ-011 SHALL have port pulse_ch  output  $clog2(NUM_CH)  channel owning the current or last hold.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion strobe.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, GAP.
REQ-015 SHALL, in IDLE, assert req_rdy for exactly one requesting channel, chosen round-robin starting at the pointer; req_rdy SHALL be all-zero outside IDLE or when req_vld is zero.
REQ-016 SHALL accept a request on a clock edge where req_vld[i] and req_rdy[i] are both high. On accept it SHALL latch req_hold[i] and i, move the pointer to (i+1) mod NUM_CH, and enter HOLD.
REQ-017 SHALL drive pulse_out high from the cycle after accept for exactly N cycles, N = latched hold; hold value 0 SHALL be treated as 1.
REQ-018 SHALL use a down-counter loaded with N-1 on accept and leave HOLD when the counter is 0; the counter SHALL not wrap.
REQ-019 SHALL assert done for one cycle coincident with the last pulse_out-high cycle.
REQ-020 SHALL, after HOLD, spend GAP_CYC cycles in GAP with pulse_out low, then return to IDLE; if GAP_CYC=0 it SHALL go directly from HOLD to IDLE.
REQ-021 SHALL, with abort high in HOLD, drop pulse_out on the next edge, enter GAP, and suppress done; abort SHALL be ignored in IDLE and GAP.
REQ-022 SHALL hold pulse_ch stable from accept until the next accept.
REQ-023 SHALL ignore req_vld changes and req_hold changes after accept (no re-trigger, no length change).
REQ-024 SHALL give a requester that holds req_vld high a grant within NUM_CH accepts (starvation-free).
REQ-025 SHALL treat req_vld deasserting before accept as a withdrawn request, with no state change.

Reset
REQ-026 SHALL, on rst, force state IDLE, pointer 0, counter 0, pulse_out 0, pulse_ch 0, busy 0, done 0; req_rdy SHALL then follow REQ-015.
REQ-027 SHALL, on rst mid-HOLD, drop pulse_out immediately (asynchronously) and emit no done.

Structure
REQ-028 SHALL place the FSM state enum typedef and default parameter constants (NUM_CH, CNT_W, GAP_CYC) in shared package pulse_pkg.
REQ-029 SHALL instantiate one sub-module rr_arbiter (req vector, pointer in, one-hot grant out, combinational).

Verification
REQ-030 SHALL cover single request: ch2 req_hold=5 at cycle 10 -> accept at 10, pulse_out high 11..15, done at 15, pulse_ch=2, busy low at 17 (GAP_CYC=1).
REQ-031 SHALL cover all 4 channels requesting continuously with hold=3 -> grant order 0,1,2,3,0; each pulse is 3 cycles, with 1 low cycle between pulses.
REQ-032 SHALL cover zero hold: req_hold=0 -> pulse_out high exactly 1 cycle, and done in that cycle.
REQ-033 SHALL cover abort: hold=100, abort at 4th high cycle -> pulse_out low next cycle, no done, GAP then IDLE.
REQ-034 SHALL cover async reset mid-hold: rst pulse during HOLD -> all outputs 0 immediately, and the next grant goes to channel 0.
REQ-035 SHALL cover a withdrawn request: req_vld[1] high only while busy, dropped before IDLE -> no accept for channel 1, and req_rdy stays 0.
